// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: measures sync timing, tracks pixel position, classifies
// pixel colours and locks once two consecutive frames show identical timing.
module vga_rx_monitor #(
  parameter logic [11:0] bgColor = 12'h00f,
  parameter logic [11:0] fgColor = 12'hf00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic        px_is_fg,
  output logic        px_is_bg,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [11:0] v_total,
  output logic [11:0] v_sync_w,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_hs, r_hs_d, r_vs, r_vs_d;
  logic [11:0] r_rgb;
  logic [11:0] r_hcnt, r_hlow, r_vcnt, r_vlow;
  logic [11:0] r_h_total, r_h_sync_w, r_v_total, r_v_sync_w;
  logic [9:0]  r_px_x, r_px_y;
  logic        r_y_arm;
  logic        r_px_valid, r_px_is_fg, r_px_is_bg, r_frame_start, r_locked, r_err;
  logic [11:0] r_ref_ht, r_ref_vt;
  logic        r_ht_valid, r_vt_valid, r_line_bad;

  logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_pix_on;
  logic [11:0] w_ht_new;
  logic        w_line_diff, w_frame_clean, w_lock_miss;

  function automatic logic [11:0] sat12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] sat10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  // Edges compare the newest registered sample against the one before it.
  assign w_hs_fall     = r_hs_d & ~r_hs;
  assign w_hs_rise     = ~r_hs_d & r_hs;
  assign w_vs_fall     = r_vs_d & ~r_vs;
  assign w_vs_rise     = ~r_vs_d & r_vs;
  assign w_pix_on      = r_hs & r_vs & (r_rgb != 12'h000);
  assign w_ht_new      = sat12(r_hcnt);
  assign w_line_diff   = w_hs_fall & r_ht_valid & (w_ht_new != r_ref_ht);
  assign w_frame_clean = ~r_line_bad & ~w_line_diff;
  assign w_lock_miss   = (w_hs_fall & (w_ht_new != r_ref_ht)) |
                         (w_vs_fall & (r_vcnt != r_ref_vt));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_SEARCH;
      r_hs          <= 1'b1;
      r_hs_d        <= 1'b1;
      r_vs          <= 1'b1;
      r_vs_d        <= 1'b1;
      r_rgb         <= 12'd0;
      r_hcnt        <= 12'd0;
      r_hlow        <= 12'd0;
      r_vcnt        <= 12'd0;
      r_vlow        <= 12'd0;
      r_h_total     <= 12'd0;
      r_h_sync_w    <= 12'd0;
      r_v_total     <= 12'd0;
      r_v_sync_w    <= 12'd0;
      r_px_x        <= 10'd0;
      r_px_y        <= 10'd0;
      r_y_arm       <= 1'b0;
      r_px_valid    <= 1'b0;
      r_px_is_fg    <= 1'b0;
      r_px_is_bg    <= 1'b0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_ref_ht      <= 12'd0;
      r_ref_vt      <= 12'd0;
      r_ht_valid    <= 1'b0;
      r_vt_valid    <= 1'b0;
      r_line_bad    <= 1'b0;
    end else begin
      r_px_valid    <= 1'b0;
      r_px_is_fg    <= 1'b0;
      r_px_is_bg    <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_hs   <= hsync;
        r_hs_d <= r_hs;
        r_vs   <= vsync;
        r_vs_d <= r_vs;
        r_rgb  <= {R, G, B};

        if (w_hs_fall) begin
          r_hcnt    <= 12'd0;
          r_h_total <= w_ht_new;
          r_hlow    <= 12'd1;
        end else begin
          r_hcnt <= sat12(r_hcnt);
          if (!r_hs) r_hlow <= sat12(r_hlow);
        end
        if (w_hs_rise) r_h_sync_w <= r_hlow;

        // A line start coincident with the frame start is line 1 of the new frame.
        if (w_vs_fall) begin
          r_vcnt        <= w_hs_fall ? 12'd1 : 12'd0;
          r_vlow        <= w_hs_fall ? 12'd1 : 12'd0;
          r_v_total     <= r_vcnt;
          r_frame_start <= 1'b1;
        end else if (w_hs_fall) begin
          r_vcnt <= sat12(r_vcnt);
          if (!r_vs) r_vlow <= sat12(r_vlow);
        end
        if (w_vs_rise) r_v_sync_w <= r_vlow;

        r_px_x <= w_hs_rise ? 10'd0 : sat10(r_px_x);
        if (w_vs_rise) r_y_arm <= 1'b1;
        if (w_hs_rise) begin
          if (r_y_arm || w_vs_rise) begin
            r_px_y  <= 10'd0;
            r_y_arm <= 1'b0;
          end else begin
            r_px_y <= sat10(r_px_y);
          end
        end

        r_px_valid <= w_pix_on;
        r_px_is_fg <= w_pix_on && (r_rgb == fgColor);
        r_px_is_bg <= w_pix_on && (r_rgb == bgColor) && (bgColor != fgColor);

        case (r_state)
          ST_SEARCH: begin
            if (w_vs_fall) begin
              r_state    <= ST_MEASURE;
              r_ht_valid <= 1'b0;
              r_vt_valid <= 1'b0;
              r_line_bad <= 1'b0;
            end
          end
          ST_MEASURE: begin
            if (w_hs_fall) begin
              r_ref_ht   <= w_ht_new;
              r_ht_valid <= 1'b1;
              if (w_line_diff) r_line_bad <= 1'b1;
            end
            // The line closed on this sample belongs to the frame ending here.
            if (w_vs_fall) begin
              if (w_frame_clean && r_vt_valid && (r_vcnt == r_ref_vt)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
              r_ref_vt   <= r_vcnt;
              r_vt_valid <= w_frame_clean;
              r_line_bad <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_lock_miss) begin
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_err    <= 1'b1;
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign px_valid    = r_px_valid;
  assign px_is_fg    = r_px_is_fg;
  assign px_is_bg    = r_px_is_bg;
  assign h_total     = r_h_total;
  assign h_sync_w    = r_h_sync_w;
  assign v_total     = r_v_total;
  assign v_sync_w    = r_v_sync_w;
  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule
